mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter I_ADDR_BITS, default 6, instruction-fetch byte-address width.
REQ-002 SHALL have parameter D_ADDR_BITS, default 6, data-access byte-address width.
REQ-003 SHALL have parameter MEM_ADDR_BITS, default 6, shared-memory byte-address width.
REQ-004 SHALL have parameter MAX_D_BURST, default 4, consecutive data grants allowed while a fetch waits.
REQ-005 SHALL use one clock, clk, with an asynchronous, active-low reset, rst_n.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 if_req  input  1  fetch request, held with if_addr until if_ack.
REQ-009 if_addr  input  I_ADDR_BITS  fetch byte address.
REQ-010 if_ack  output  1  one-cycle fetch completion pulse.
REQ-011 if_rdata  output  32  fetched instruction.
REQ-012 d_req  input  1  data request, held with d_we/d_addr/d_wdata until d_ack.
REQ-013 d_we  input  1  1 = store, 0 = load.
REQ-014 d_addr  input  D_ADDR_BITS  data byte address.
REQ-015 d_wdata  input  64  store data.
REQ-016 d_ack  output  1  one-cycle data completion pulse.
REQ-017 d_rdata  output  64  load data.
REQ-018 mem_req  output  1  shared-memory access strobe.
REQ-019 mem_we  output  1  shared-memory write enable.
REQ-020 mem_addr  output  MEM_ADDR_BITS  shared-memory byte address.
REQ-021 mem_wdata  output  64  shared-memory write data.
REQ-022 mem_rdata  input  64  shared-memory read data, valid when mem_ready=1.
REQ-023 mem_ready  input  1  memory completion, may be high in the first mem_req cycle.
REQ-024 busy  output  1  high when state is not IDLE.

Function
REQ-025 SHALL implement states IDLE, BUSY_I, BUSY_D, all outputs registered.
REQ-026 In IDLE, if any request is eligible at a rising edge, SHALL latch the winner's address, we, and wdata, and enter BUSY_I or BUSY_D with mem_req=1 from the next cycle.
REQ-027 Arbitration SHALL give priority to data over fetch, except when d_streak==MAX_D_BURST and if_req=1; then fetch wins.
REQ-028 d_streak (width clog2(MAX_D_BURST+1)) SHALL increment, saturating, on each data grant made while if_req=1; it SHALL clear on every fetch grant.
REQ-029 A requester whose ack is high in the current cycle SHALL be ineligible at the next edge.
REQ-030 Addresses SHALL be zero-extended or truncated to MEM_ADDR_BITS; a fetch SHALL drive mem_we=0 and mem_wdata=0.
REQ-031 In BUSY_x, mem_req, mem_we, mem_addr, and mem_wdata SHALL remain stable until mem_ready is sampled high.
REQ-032 On the edge sampling mem_ready=1, SHALL return to IDLE, drive mem_req=0 and mem_we=0, and pulse the matching ack for exactly one cycle.
REQ-033 On that same edge, a fetch SHALL load if_rdata with mem_rdata[31:0] if the latched address bit 2 is 0, else mem_rdata[63:32].
REQ-034 On that same edge, a load SHALL load d_rdata with mem_rdata; a store SHALL leave d_rdata unchanged.
REQ-035 if_rdata and d_rdata SHALL hold their values between acks.
REQ-036 Minimum latency SHALL be: request sampled at edge N, mem_req high after N, mem_ready high in that cycle, ack high after edge N+1.
REQ-037 An accepted transaction SHALL never be preempted, whatever the request activity.
REQ-038 SHALL enforce at least one IDLE cycle between grants: ack cycle, then re-arbitration at the following edge.

Reset
REQ-039 rst_n low SHALL, asynchronously, force state=IDLE, d_streak=0, and all outputs (if_ack, d_ack, mem_req, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata) to 0.
REQ-040 Reset during BUSY_x SHALL abandon the transaction with no ack; after release, the first edge with requests high SHALL arbitrate anew.

Verification
REQ-041 Load, mem_ready tied 1: d_req=1, d_we=0, d_addr=0x10, mem_rdata=0xDEADBEEF_01234567 -> mem_addr=0x10, d_ack two edges after request, d_rdata=0xDEADBEEF_01234567.
REQ-042 Fetch halves: if_addr=0x04, mem_rdata=0xAAAA5555_12345678 -> if_rdata=0xAAAA5555; with if_addr=0x00 -> if_rdata=0x12345678.
REQ-043 Simultaneous if_req and d_req, d_streak=0 -> data granted first, fetch granted after the idle cycle; d_streak=1, then 0.
REQ-044 Starvation: d_req re-asserted continuously with if_req held, MAX_D_BURST=4 -> exactly 4 data acks, then if_ack, then data resumes.
REQ-045 Wait states: mem_ready low for 3 cycles in BUSY_D (store, d_wdata=0x55) -> mem_* stable all 3 cycles, single d_ack after ready, d_rdata unchanged.
REQ-046 rst_n pulsed low during BUSY_I -> all outputs 0 immediately, no if_ack; re-requested fetch completes normally after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared 64-bit memory port between an instruction-fetch and a data requester.
// Data has priority unless it has been granted MAX_D_BURST times in a row while a fetch waited.
module mem_port_arbiter #(
  parameter int I_ADDR_BITS   = 6,
  parameter int D_ADDR_BITS   = 6,
  parameter int MEM_ADDR_BITS = 6,
  parameter int MAX_D_BURST   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [I_ADDR_BITS-1:0]   if_addr,
  output logic                     if_ack,
  output logic [31:0]              if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [D_ADDR_BITS-1:0]   d_addr,
  input  logic [63:0]              d_wdata,
  output logic                     d_ack,
  output logic [63:0]              d_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [63:0]              mem_wdata,
  input  logic [63:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int SW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [SW-1:0]            streak_r, streak_s;
  logic                     fetch_hi_r, fetch_hi_s;
  logic                     mem_req_r, mem_req_s;
  logic                     mem_we_r, mem_we_s;
  logic [MEM_ADDR_BITS-1:0] mem_addr_r, mem_addr_s;
  logic [63:0]              mem_wdata_r, mem_wdata_s;
  logic                     if_ack_r, if_ack_s;
  logic                     d_ack_r, d_ack_s;
  logic [31:0]              if_rdata_r, if_rdata_s;
  logic [63:0]              d_rdata_r, d_rdata_s;
  logic                     busy_r, busy_s;

  // A requester being acked this cycle is still showing its old request, so it sits out one edge.
  logic i_elig_s, d_elig_s, fetch_win_s;
  assign i_elig_s    = if_req & ~if_ack_r;
  assign d_elig_s    = d_req & ~d_ack_r;
  assign fetch_win_s = i_elig_s & (~d_elig_s | (streak_r == STREAK_MAX));

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_s     = state_r;
    streak_s    = streak_r;
    fetch_hi_s  = fetch_hi_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_rdata_s  = if_rdata_r;
    d_rdata_s   = d_rdata_r;
    if_ack_s    = 1'b0;
    d_ack_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_win_s) begin
          state_s     = BUSY_I;
          streak_s    = '0;
          fetch_hi_s  = if_addr[2];
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = MEM_ADDR_BITS'({{MEM_ADDR_BITS{1'b0}}, if_addr});
          mem_wdata_s = 64'd0;
        end else if (d_elig_s) begin
          state_s     = BUSY_D;
          mem_req_s   = 1'b1;
          mem_we_s    = d_we;
          mem_addr_s  = MEM_ADDR_BITS'({{MEM_ADDR_BITS{1'b0}}, d_addr});
          mem_wdata_s = d_wdata;
          if (if_req && (streak_r != STREAK_MAX)) begin
            streak_s = streak_r + SW'(1);
          end else begin
            streak_s = streak_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_s    = IDLE;
          mem_req_s  = 1'b0;
          mem_we_s   = 1'b0;
          if_ack_s   = 1'b1;
          if_rdata_s = fetch_hi_r ? mem_rdata[63:32] : mem_rdata[31:0];
        end else begin
          state_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          d_ack_s   = 1'b1;
          if (!mem_we_r) begin
            d_rdata_s = mem_rdata;
          end else begin
            d_rdata_s = d_rdata_r;
          end
        end else begin
          state_s = BUSY_D;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      streak_r    <= '0;
      fetch_hi_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 64'd0;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
      if_rdata_r  <= 32'd0;
      d_rdata_r   <= 64'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      streak_r    <= streak_s;
      fetch_hi_r  <= fetch_hi_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_ack_r    <= if_ack_s;
      d_ack_r     <= d_ack_s;
      if_rdata_r  <= if_rdata_s;
      d_rdata_r   <= d_rdata_s;
      busy_r      <= busy_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences,
// then random traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_req, mem_we, mem_ready, busy;
  logic [5:0]  if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata;
  logic [63:0] d_wdata, d_rdata, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.I_ADDR_BITS(6), .D_ADDR_BITS(6), .MEM_ADDR_BITS(6), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    mem_ready = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    chk("vec_grant_req", {63'd0, mem_req}, 64'd1);
    chk("vec_grant_addr", {58'd0, mem_addr}, {58'd0, v.addr});
    chk("vec_grant_we", {63'd0, mem_we}, v.fetch ? 64'd0 : {63'd0, v.we});
    chk("vec_grant_wdata", mem_wdata, v.fetch ? 64'd0 : v.wdata);
    @(negedge clk);
    chk("vec_ack", {63'd0, v.fetch ? if_ack : d_ack}, 64'd1);
    chk("vec_rdata", v.fetch ? {32'd0, if_rdata} : d_rdata, v.exp_rd);
    chk("vec_ack_memreq", {63'd0, mem_req}, 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("vec_ack_pulse", {62'd0, if_ack, d_ack}, 64'd0);
    chk("vec_idle", {63'd0, busy}, 64'd0);
  endtask

  // Transaction-level reference model state
  int          m_phase;   // 0 idle, 1 fetch in flight, 2 data in flight
  int          m_streak;
  logic        m_req, m_we, m_if_ack, m_d_ack;
  logic [5:0]  m_addr;
  logic [63:0] m_wdata, m_drd;
  logic [31:0] m_ird;

  task automatic model_step();
    logic n_if_ack, n_d_ack, ei, ed;
    n_if_ack = 1'b0; n_d_ack = 1'b0;
    if (m_phase != 0) begin
      if (mem_ready) begin
        if (m_phase == 1) begin
          n_if_ack = 1'b1;
          m_ird = m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end else begin
          n_d_ack = 1'b1;
          if (!m_we) m_drd = mem_rdata;
        end
        m_phase = 0; m_req = 1'b0; m_we = 1'b0;
      end
    end else begin
      ei = if_req && !m_if_ack;
      ed = d_req && !m_d_ack;
      if (ei && (!ed || m_streak == MAXB)) begin
        m_phase = 1; m_streak = 0; m_req = 1'b1; m_we = 1'b0; m_addr = if_addr; m_wdata = 64'd0;
      end else if (ed) begin
        m_phase = 2; m_req = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        if (if_req && m_streak < MAXB) m_streak = m_streak + 1;
      end
    end
    m_if_ack = n_if_ack; m_d_ack = n_d_ack;
  endtask

  logic [63:0] exp_drd;
  logic [63:0] r43, r44;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 6'h10, 64'd0, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567};
    vecs[1] = '{1'b1, 1'b0, 6'h04, 64'd0, 64'hAAAA5555_12345678, 64'h00000000_AAAA5555};
    vecs[2] = '{1'b1, 1'b0, 6'h00, 64'd0, 64'hAAAA5555_12345678, 64'h00000000_12345678};
    vecs[3] = '{1'b0, 1'b1, 6'h08, 64'h55, 64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_01234567};
    vecs[4] = '{1'b0, 1'b0, 6'h3C, 64'd0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
    vecs[5] = '{1'b1, 1'b0, 6'h3C, 64'd0, 64'h11112222_33334444, 64'h00000000_11112222};
    r43 = 64'h0F0F0F0F_A5A5C3C3;
    r44 = 64'h13579BDF_2468ACE0;

    rst_n = 1'b0; if_req = 1'b0; if_addr = 6'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 6'd0;
    d_wdata = 64'd0; mem_ready = 1'b0; mem_rdata = 64'd0;
    #12;
    chk("reset_ctrl", {55'd0, if_ack, d_ack, mem_req, mem_we, busy, 4'd0}, 64'd0);
    chk("reset_addr_wdata", mem_wdata | {58'd0, mem_addr}, 64'd0);
    chk("reset_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    exp_drd = 64'h01234567_89ABCDEF;

    // Simultaneous requests: data first, fetch at the edge after the data ack
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'h20; if_req = 1'b1; if_addr = 6'h08;
    mem_ready = 1'b1; mem_rdata = r43;
    @(negedge clk);
    chk("simul_first_data", {57'd0, mem_req, mem_addr}, {57'd0, 1'b1, 6'h20});
    @(negedge clk);
    chk("simul_d_ack", {62'd0, d_ack, if_ack}, 64'd2);
    chk("simul_d_rdata", d_rdata, r43);
    exp_drd = r43;
    d_req = 1'b0;
    @(negedge clk);
    chk("simul_then_fetch", {57'd0, mem_req, mem_addr}, {57'd0, 1'b1, 6'h08});
    @(negedge clk);
    chk("simul_if_ack", {63'd0, if_ack}, 64'd1);
    chk("simul_if_rdata", {32'd0, if_rdata}, {32'd0, r43[31:0]});
    if_req = 1'b0;
    @(negedge clk);

    // Burst limit: four data grants while a fetch waits, then the fetch overrides data
    mem_rdata = r44;
    for (int k = 0; k < MAXB; k++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 6'h30; if_req = 1'b1; if_addr = 6'h0C;
      @(negedge clk);
      chk($sformatf("burst_data_%0d", k), {57'd0, mem_req, mem_addr}, {57'd0, 1'b1, 6'h30});
      @(negedge clk);
      chk($sformatf("burst_d_ack_%0d", k), {63'd0, d_ack}, 64'd1);
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
    end
    exp_drd = r44;
    @(negedge clk);
    d_req = 1'b1; if_req = 1'b1;
    @(negedge clk);
    chk("burst_fetch_wins", {56'd0, mem_req, mem_we, mem_addr}, {56'd0, 1'b1, 1'b0, 6'h0C});
    @(negedge clk);
    chk("burst_if_ack", {63'd0, if_ack}, 64'd1);
    chk("burst_if_rdata_hi", {32'd0, if_rdata}, {32'd0, r44[63:32]});
    if_req = 1'b0;
    @(negedge clk);
    chk("burst_data_resumes", {57'd0, mem_req, mem_addr}, {57'd0, 1'b1, 6'h30});
    @(negedge clk);
    chk("burst_resume_ack", {63'd0, d_ack}, 64'd1);
    d_req = 1'b0;
    @(negedge clk);

    // Wait states on a store: port held stable, single ack, load data untouched
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'h18; d_wdata = 64'h55; mem_ready = 1'b0;
    mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk($sformatf("wait_stable_%0d", w), {mem_wdata[55:0], mem_req, mem_we, mem_addr},
          {56'h55, 1'b1, 1'b1, 6'h18});
      chk($sformatf("wait_no_ack_%0d", w), {63'd0, d_ack}, 64'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wait_d_ack", {63'd0, d_ack}, 64'd1);
    chk("wait_d_rdata_kept", d_rdata, exp_drd);
    d_req = 1'b0;
    @(negedge clk);
    chk("wait_single_ack", {62'd0, d_ack, mem_req}, 64'd0);

    // Reset in the middle of a fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 6'h04; mem_ready = 1'b0; mem_rdata = 64'hAAAA5555_12345678;
    @(negedge clk);
    chk("rst_busy_before", {62'd0, busy, mem_req}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {59'd0, if_ack, d_ack, mem_req, mem_we, busy}, 64'd0);
    chk("rst_async_data", mem_wdata | d_rdata | {32'd0, if_rdata} | {58'd0, mem_addr}, 64'd0);
    @(negedge clk);
    chk("rst_no_if_ack", {63'd0, if_ack}, 64'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_regrant", {57'd0, mem_req, mem_addr}, {57'd0, 1'b1, 6'h04});
    @(negedge clk);
    chk("rst_if_ack", {63'd0, if_ack}, 64'd1);
    chk("rst_if_rdata", {32'd0, if_rdata}, 64'hAAAA5555);
    if_req = 1'b0;
    @(negedge clk);

    // Random traffic against the reference model
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; m_streak = 0; m_req = 1'b0; m_we = 1'b0; m_if_ack = 1'b0; m_d_ack = 1'b0;
    m_addr = 6'd0; m_wdata = 64'd0; m_drd = 64'd0; m_ird = 32'd0;
    model_step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_ctrl", {60'd0, mem_req, busy, if_ack, d_ack},
          {60'd0, m_req, (m_phase != 0), m_if_ack, m_d_ack});
      chk("rnd_if_rdata", {32'd0, if_rdata}, {32'd0, m_ird});
      chk("rnd_d_rdata", d_rdata, m_drd);
      if (m_req) begin
        chk("rnd_mem_cmd", {57'd0, mem_we, mem_addr}, {57'd0, m_we, m_addr});
        chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      if (m_if_ack) begin
        if ($urandom_range(1, 0) == 1) if_addr = 6'($urandom);
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(2, 0) == 0) begin
        if_req = 1'b1; if_addr = 6'($urandom);
      end
      if (m_d_ack) begin
        if ($urandom_range(1, 0) == 1) begin
          d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = {$urandom, $urandom};
        end else d_req = 1'b0;
      end else if (!d_req && $urandom_range(2, 0) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = {$urandom, $urandom};
      end
      mem_ready = ($urandom_range(2, 0) != 0);
      mem_rdata = {$urandom, $urandom};
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
